// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one byte per frame and sends it LSB first
// with optional even parity and one or two stop bits; counts completed frames.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk_r,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        buf_empty,
  input  logic [7:0]  buf_out,
  output logic        rd_en,
  output logic        tx,
  output logic        tx_busy,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam logic [15:0] TMR_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state;
  logic [7:0]  shreg;
  logic        parity;
  logic [15:0] bit_tmr;
  logic [2:0]  bit_idx;
  logic        bit_done;

  assign bit_done  = (bit_tmr == TMR_LAST);
  assign tx_busy   = (state != IDLE);
  assign state_dbg = state;

  // Pop handshake: rd_en is a one-cycle pulse issued only from IDLE when the FIFO
  // is non-empty; buf_out is taken in LOAD, the cycle after the FIFO saw the pop.
  always_ff @(posedge clk_r or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= 8'd0;
      parity    <= 1'b0;
      bit_tmr   <= 16'd0;
      bit_idx   <= 3'd0;
      rd_en     <= 1'b0;
      tx        <= 1'b1;
      frame_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_tmr <= 16'd0;
          bit_idx <= 3'd0;
          if (tx_en && !buf_empty) begin
            rd_en <= 1'b1;
            state <= POP;
          end
        end
        POP: begin
          rd_en <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          shreg   <= buf_out;
          parity  <= ^buf_out;
          tx      <= 1'b0;
          bit_tmr <= 16'd0;
          state   <= START;
        end
        START: begin
          if (bit_done) begin
            bit_tmr <= 16'd0;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_tmr <= bit_tmr + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_tmr <= 16'd0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            bit_tmr <= bit_tmr + 16'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            bit_tmr <= 16'd0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            bit_tmr <= bit_tmr + 16'd1;
          end
        end
        STOP: begin
          // bit_idx counts stop bits so two stop bits never overflow bit_tmr
          if (bit_done) begin
            bit_tmr <= 16'd0;
            if (bit_idx == STOP_LAST) begin
              bit_idx   <= 3'd0;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_tmr <= bit_tmr + 16'd1;
          end
        end
        default: begin
          rd_en <= 1'b0;
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity/1 stop, parity/2 stops) fed by
// queue-based FIFO models; a UART receiver monitor checks frames against exp queues.
module tb_fifo_uart_tx;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int CPB = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        tx_en_a, buf_empty_a, rd_en_a, tx_a, tx_busy_a;
  logic [7:0]  buf_out_a;
  logic [15:0] frame_cnt_a;
  logic [2:0]  state_a;
  logic        tx_en_b, buf_empty_b, rd_en_b, tx_b, tx_busy_b;
  logic [7:0]  buf_out_b;
  logic [15:0] frame_cnt_b;
  logic [2:0]  state_b;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk_r(clk), .rst(rst_n), .tx_en(tx_en_a), .buf_empty(buf_empty_a),
    .buf_out(buf_out_a), .rd_en(rd_en_a), .tx(tx_a), .tx_busy(tx_busy_a),
    .frame_cnt(frame_cnt_a), .state_dbg(state_a));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk_r(clk), .rst(rst_n), .tx_en(tx_en_b), .buf_empty(buf_empty_b),
    .buf_out(buf_out_b), .rd_en(rd_en_b), .tx(tx_b), .tx_busy(tx_busy_b),
    .frame_cnt(frame_cnt_b), .state_dbg(state_b));

  logic [1:0]       tx_w, busy_w, rd_w;
  logic [1:0][15:0] fcnt_w;
  assign tx_w   = {tx_b, tx_a};
  assign busy_w = {tx_busy_b, tx_busy_a};
  assign rd_w   = {rd_en_b, rd_en_a};
  assign fcnt_w = {frame_cnt_b, frame_cnt_a};

  // FIFO models: data appears on buf_out the cycle after a sampled pop
  logic [7:0] fq_a[$];
  logic [7:0] fq_b[$];
  always @(posedge clk) begin
    if (rd_en_a && fq_a.size() > 0) buf_out_a <= fq_a.pop_front();
    if (rd_en_b && fq_b.size() > 0) buf_out_b <= fq_b.pop_front();
  end
  always @(negedge clk) begin
    #1;
    buf_empty_a = (fq_a.size() == 0);
    buf_empty_b = (fq_b.size() == 0);
  end

  // scoreboard
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];
  int falls_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // rd_en monitor
  int   rd_cnt[2]  = '{0, 0};
  int   rd_rise[2] = '{0, 0};
  logic rd_prev[2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_w[k]) begin
        rd_cnt[k]++;
        rd_rise[k] = cyc;
        check("rd_pulse_width", int'(rd_prev[k]), 0);
        check("busy_at_pop", int'(busy_w[k]), 1);
      end
      rd_prev[k] = rd_w[k];
    end
  end

  // UART receiver: samples mid-bit, aborts if reset is seen
  task automatic mon_frame(input int which, input int nbits, output logic [11:0] got,
                           output bit aborted);
    got = '0;
    aborted = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (CPB) @(negedge clk);
      if (!rst_n) begin
        aborted = 1'b1;
        return;
      end
      got[i] = tx_w[which];
    end
  endtask

  task automatic mon_loop(input int which, input int nbits);
    logic [11:0] got;
    logic [11:0] exp;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n && !tx_w[which]) begin
        if (which == 1) falls_b.push_back(cyc);
        check("start_latency", cyc - rd_rise[which], 2);
        mon_frame(which, nbits, got, ab);
        if (!ab) begin
          exp = '1;
          if (which == 0 && exp_q_a.size() > 0) exp = exp_q_a.pop_front();
          if (which == 1 && exp_q_b.size() > 0) exp = exp_q_b.pop_front();
          check("frame_bits", int'(got), int'(exp));
        end
      end
    end
  endtask

  initial mon_loop(0, 10);
  initial mon_loop(1, 12);

  // driver helpers
  task automatic wait_done(input int which, input int target, input int bound, output int at);
    int n = 0;
    while (n < bound && !(fcnt_w[which] == 16'(target) && !busy_w[which])) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check("frame_done_in_time", int'(n < bound), 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t_done;
    int n;
    rst_n   = 1'b0;
    tx_en_a = 1'b0;
    tx_en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx_a), 1);
    check("rst_rd_en", int'(rd_en_a), 0);
    check("rst_busy", int'(tx_busy_a), 0);
    check("rst_frame_cnt", int'(frame_cnt_a), 0);
    check("rst_state", int'(state_a), 0);
    rst_n = 1'b1;

    // empty FIFO with enable: no pop
    tx_en_a = 1'b1;
    repeat (20) @(negedge clk);
    check("no_pop_when_empty", rd_cnt[0], 0);
    check("idle_line_high", int'(tx_a), 1);

    // data present but disabled: no pop
    tx_en_a = 1'b0;
    fq_a.push_back(8'hA5);
    repeat (20) @(negedge clk);
    check("no_pop_when_disabled", rd_cnt[0], 0);

    // single frame 0xA5: 0,1,0,1,0,0,1,0,1,1
    exp_q_a.push_back(12'h34A);
    tx_en_a = 1'b1;
    wait_done(0, 1, 200, t_done);
    check("single_busy_len", t_done - rd_rise[0], 42);
    check("single_frame_cnt", int'(frame_cnt_a), 1);
    check("single_rd_cnt", rd_cnt[0], 1);

    // drop tx_en mid-frame: 0x3C completes, 0x5A stays in the FIFO
    exp_q_a.push_back(12'h278);
    fq_a.push_back(8'h3C);
    fq_a.push_back(8'h5A);
    n = 0;
    while (rd_cnt[0] < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("second_pop_seen", int'(rd_cnt[0] == 2), 1);
    repeat (10) @(negedge clk);
    tx_en_a = 1'b0;
    wait_done(0, 2, 200, t_done);
    repeat (60) @(negedge clk);
    check("drop_en_rd_cnt", rd_cnt[0], 2);
    check("drop_en_frame_cnt", int'(frame_cnt_a), 2);
    fq_a.delete();
    repeat (3) @(negedge clk);

    // tx_en rise and buf_empty fall before the same edge
    exp_q_a.push_back(12'h302);
    fq_a.push_back(8'h81);
    tx_en_a = 1'b1;
    t0 = cyc;
    wait_done(0, 3, 200, t_done);
    check("simul_pop_edge", rd_rise[0] - t0, 1);

    // counter wrap: preload 0xFFFF, one more frame gives 0x0000
    force dut_a.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_cnt;
    exp_q_a.push_back(12'h200);
    fq_a.push_back(8'h00);
    wait_done(0, 0, 200, t_done);
    check("wrap_frame_cnt", int'(frame_cnt_a), 0);

    // back-to-back with parity and two stop bits: 0x01 (parity 1), 0x03 (parity 0)
    exp_q_b.push_back(12'hE02);
    exp_q_b.push_back(12'hC06);
    fq_b.push_back(8'h01);
    fq_b.push_back(8'h03);
    tx_en_b = 1'b1;
    wait_done(1, 2, 400, t_done);
    check("b2b_rd_cnt", rd_cnt[1], 2);
    check("b2b_frame_cnt", int'(frame_cnt_b), 2);
    check("b2b_falls", falls_b.size(), 2);
    if (falls_b.size() >= 2) check("b2b_spacing", falls_b[1] - falls_b[0], 12 * CPB + 3);
    check("exp_a_drained", exp_q_a.size(), 0);
    check("exp_b_drained", exp_q_b.size(), 0);

    // reset mid-frame: byte is lost, outputs clear without a clock edge
    fq_b.push_back(8'h55);
    n = 0;
    while (tx_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("third_frame_started", int'(tx_b), 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", int'(tx_b), 1);
    check("mid_rst_rd_en", int'(rd_en_b), 0);
    check("mid_rst_busy", int'(tx_busy_b), 0);
    check("mid_rst_frame_cnt", int'(frame_cnt_b), 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle_high", int'(tx_b), 1);
    check("post_rst_rd_cnt", rd_cnt[1], 3);
    check("post_rst_frame_cnt", int'(frame_cnt_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the dual-clock FIFO. It runs in the FIFO read clock domain, pops one byte at a time through the FIFO read port, and serialises each byte onto a UART line. The frame is LSB first, with optional even parity and one or two stop bits. A frame counter is provided for debug and bring-up.

## Interface

Parameters:
- CLKS_PER_BIT, default 16: clk_r cycles per UART bit; legal range 2..65535.
- PARITY_EN, default 0: 1 inserts an even-parity bit after data bit 7.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.

Ports:
- clk_r  in  1  read-domain clock, shared with the FIFO read port.
- rst  in  1  asynchronous, active-low reset; all state clears while rst = 0.
- tx_en  in  1  allows new frames to start; sampled only in IDLE.
- buf_empty  in  1  FIFO empty flag.
- buf_out  in  8  FIFO read data; valid on the cycle after rd_en was sampled high.
- rd_en  out  1  FIFO pop request; registered; one-cycle pulse.
- tx  out  1  UART serial line; idles high.
- tx_busy  out  1  high in every state except IDLE.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF -> 0x0000.

## Operation

State machine: IDLE, POP, LOAD, START, DATA, PARITY, STOP.

- **IDLE**
  - tx = 1.
  - If tx_en = 1 and buf_empty = 0: rd_en <= 1, go to POP.
- **POP**
  - rd_en <= 0; the FIFO samples the pop on this edge. Go to LOAD.
- **LOAD**
  - shreg <= buf_out, parity <= ^buf_out, tx <= 0, bit_tmr <= 0. Go to START.
- **START**
  - tx held at 0 for CLKS_PER_BIT cycles, then DATA with bit_idx = 0 and tx <= shreg[0].
- **DATA**
  - Each bit is held for CLKS_PER_BIT cycles.
  - After bit_idx 7: go to PARITY if PARITY_EN = 1, otherwise to STOP.
- **PARITY**
  - tx = parity for CLKS_PER_BIT cycles, then STOP.
- **STOP**
  - tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On exit: frame_cnt <= frame_cnt + 1, go to IDLE.

Arithmetic and widths:
- bit_tmr is 16 bits and compares against CLKS_PER_BIT − 1.
- bit_idx is 3 bits.
- frame_cnt is 16 bits, modulo 2^16.

## Timing

Reset values: tx = 1, rd_en = 0, tx_busy = 0, frame_cnt = 0. All internal state returns to IDLE with counters at 0.

Latency, counted from the edge E at which rd_en is set to 1:
- rd_en is high for exactly one cycle, E to E+1.
- tx falls at E+2.
- tx_busy rises at E.

Frame length on tx: (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.

Back-to-back frames:
- IDLE lasts one cycle between frames, so the next rd_en is set one edge after STOP exits.
- Start-bit falling edges are therefore spaced frame length + 3 cycles apart.

Handshake rules:
- At most one pop is outstanding.
- rd_en is never asserted outside the IDLE→POP transition.
- rd_en is never asserted while buf_empty = 1 is sampled in IDLE.

Boundary conditions:
- **tx_en drops mid-frame:** the current frame completes unchanged; the block then stays in IDLE.
- **FIFO goes empty mid-frame:** no effect on the frame in flight; the block waits in IDLE.
- **Simultaneous tx_en rise and buf_empty fall:** a pop is issued on that edge.
- **rst asserted mid-frame:**
  - tx goes to 1 immediately, without waiting for a clock edge.
  - rd_en goes to 0 and the partial frame is abandoned.
  - A byte already popped is lost.
  - frame_cnt is cleared.
- **rst released:** the first pop can occur on the first clk_r edge after release.

## Test plan

- **Reset defaults:** assert rst = 0 mid-frame. Required: tx = 1 immediately, rd_en = 0, tx_busy = 0, frame_cnt = 0 with no clock edge. After release, an idle line stays high.
- **Single frame:** CLKS_PER_BIT = 4, PARITY_EN = 0, STOP_BITS = 1; FIFO holds 0xA5.
  - Required: one rd_en pulse; tx falls 2 cycles after it.
  - tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - frame_cnt = 1; tx_busy drops after 40 cycles of frame.
- **Back-to-back with parity:** PARITY_EN = 1, STOP_BITS = 2; FIFO holds 0x01, 0x03.
  - Required: parity bits 1 then 0.
  - Start-bit falling edges are 12 × CLKS_PER_BIT + 3 cycles apart.
  - Exactly 2 rd_en pulses; frame_cnt = 2.
- **Empty and enable gating:**
  - buf_empty = 1 with tx_en = 1 → no rd_en.
  - tx_en = 0 with data present → no rd_en.
  - Drop tx_en mid-frame → frame completes and no further pop occurs.
- **Counter wrap:** preload or run 65536 frames with CLKS_PER_BIT = 2. Required: frame_cnt reads 0x0000 after the 65536th frame.
